tm_engine: RTL and testbench



---
 rtl/tm_pkg.sv | 24 ++
 rtl/tm_rule_table.sv | 53 +++++
 rtl/tm_engine.sv | 242 ++++++++++++++++++++++++
 tb/tb_tm_engine.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm_pkg.sv
// Shared types and constants for the tm_engine Turing-machine block.
// The optional nonzero-cell counter is enabled by defining TM_SIGMA_EN.
package tm_pkg;
    localparam int STATE_W = 4;
    localparam int SYM_W   = 4;
    localparam logic [STATE_W-1:0] HALT = '1;
    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    typedef enum logic [3:0] {
        IDLE, CLR_REQ, CLR_WAIT, RD_REQ, RD_WAIT, LOOKUP,
        WR_REQ, WR_WAIT, MOVE, DONE, FAULT
    } ctl_t;

    typedef struct packed {
        logic [SYM_W-1:0]   newsym;
        logic               dir;
        logic [STATE_W-1:0] next;
    } rule_t;

    localparam int RULE_W = $bits(rule_t);
    // An unprogrammed entry writes blank, moves right and halts.
    localparam rule_t RULE_RESET = '{newsym: {SYM_W{1'b0}}, dir: DIR_R, next: HALT};
endpackage

// File: rtl/tm_rule_table.sv
// Transition table: NSTATES x NSYMS rule registers with a synchronous write
// port and a registered read port. Out-of-range write addresses are dropped.
module tm_rule_table
    import tm_pkg::*;
#(
    parameter int NSTATES = 2,
    parameter int NSYMS   = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [STATE_W+SYM_W-1:0] waddr,
    input  logic [RULE_W-1:0]        wdata,
    input  logic [STATE_W-1:0]       rstate,
    input  logic [SYM_W-1:0]         rsym,
    output logic [RULE_W-1:0]        rdata
);
    rule_t tbl_q [NSTATES][NSYMS];
    rule_t tbl_d [NSTATES][NSYMS];
    rule_t rdata_q, rdata_d;

    // Address decode by comparison keeps every index inside the array bounds.
    always_comb begin
        tbl_d   = tbl_q;
        rdata_d = RULE_RESET;
        for (int s = 0; s < NSTATES; s++) begin
            for (int y = 0; y < NSYMS; y++) begin
                if (we && waddr == {STATE_W'(s), SYM_W'(y)}) begin
                    tbl_d[s][y] = rule_t'(wdata);
                end
                if (rstate == STATE_W'(s) && rsym == SYM_W'(y)) begin
                    rdata_d = tbl_q[s][y];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < NSTATES; s++) begin
                for (int y = 0; y < NSYMS; y++) begin
                    tbl_q[s][y] <= RULE_RESET;
                end
            end
            rdata_q <= RULE_RESET;
        end else begin
            tbl_q   <= tbl_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/tm_engine.sv
// Runtime-programmable Turing-machine engine with its tape in byte-wide DRAM.
// Define TM_SIGMA_EN to add the sigma output (count of nonzero tape cells).
module tm_engine
    import tm_pkg::*;
#(
    parameter int NSTATES  = 2,
    parameter int NSYMS    = 5,
    parameter int TAPE_LEN = 16384,
    parameter int ADDR_W   = 24,
    parameter int CNT_W    = 40
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     rule_we,
    input  logic [STATE_W+SYM_W-1:0] rule_addr,
    input  logic [SYM_W+STATE_W:0]   rule_wdata,
    output logic                     busy,
    output logic                     done,
    output logic                     fault,
    output logic [CNT_W-1:0]         steps,
    output logic [ADDR_W-1:0]        head,
    output logic [ADDR_W-1:0]        m_addr,
    output logic                     m_ena,
    output logic                     m_write,
    output logic [7:0]               wr_data,
    input  logic [7:0]               rd_data,
    input  logic                     m_ack,
    input  logic                     m_busy
`ifdef TM_SIGMA_EN
    ,
    output logic [ADDR_W-1:0]        sigma
`endif
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(TAPE_LEN - 1);
    localparam logic [ADDR_W-1:0] MID  = ADDR_W'(TAPE_LEN / 2);

    ctl_t               ctl_q, ctl_d;
    logic [STATE_W-1:0] tm_state_q, tm_state_d;
    logic [SYM_W-1:0]   sym_q, sym_d;
    logic [CNT_W-1:0]   steps_q, steps_d;
    logic [ADDR_W-1:0]  head_q, head_d;
    logic [ADDR_W-1:0]  m_addr_q, m_addr_d;
    logic               m_ena_q, m_ena_d;
    logic               m_write_q, m_write_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               fault_q, fault_d;
`ifdef TM_SIGMA_EN
    logic [ADDR_W-1:0]  sigma_q, sigma_d;
`endif
    logic [RULE_W-1:0]  rule_rd;
    rule_t              rule;

    // The read address follows sym_d so the rule is already registered in LOOKUP
    // and stays stable through the write and the move.
    tm_rule_table #(
        .NSTATES(NSTATES),
        .NSYMS  (NSYMS)
    ) u_table (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (rule_we && !busy_q),
        .waddr (rule_addr),
        .wdata (rule_wdata),
        .rstate(tm_state_q),
        .rsym  (sym_d),
        .rdata (rule_rd)
    );

    assign rule = rule_t'(rule_rd);

    always_comb begin
        ctl_d      = ctl_q;
        tm_state_d = tm_state_q;
        sym_d      = sym_q;
        steps_d    = steps_q;
        head_d     = head_q;
        m_addr_d   = m_addr_q;
        m_ena_d    = m_ena_q;
        m_write_d  = m_write_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        fault_d    = fault_q;
`ifdef TM_SIGMA_EN
        sigma_d    = sigma_q;
`endif
        case (ctl_q)
            IDLE, DONE, FAULT: begin
                if (start) begin
                    ctl_d      = CLR_REQ;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    fault_d    = 1'b0;
                    steps_d    = '0;
                    tm_state_d = '0;
                    m_addr_d   = LAST;
                    m_ena_d    = 1'b1;
                    m_write_d  = 1'b1;
                    wr_data_d  = 8'h00;
`ifdef TM_SIGMA_EN
                    sigma_d    = '0;
`endif
                end
            end
            CLR_REQ: begin
                if (m_ack) begin
                    m_ena_d = 1'b0;
                    ctl_d   = CLR_WAIT;
                end
            end
            CLR_WAIT: begin
                if (!m_busy) begin
                    m_ena_d = 1'b1;
                    if (m_addr_q == '0) begin
                        head_d    = MID;
                        m_addr_d  = MID;
                        m_write_d = 1'b0;
                        ctl_d     = RD_REQ;
                    end else begin
                        m_addr_d = m_addr_q - ADDR_W'(1);
                        ctl_d    = CLR_REQ;
                    end
                end
            end
            RD_REQ, WR_REQ: begin
                if (m_ack) begin
                    m_ena_d = 1'b0;
                    ctl_d   = (ctl_q == RD_REQ) ? RD_WAIT : WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (!m_busy) begin
                    sym_d = rd_data[SYM_W-1:0];
                    if (rd_data >= 8'(NSYMS)) begin
                        ctl_d   = FAULT;
                        fault_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        ctl_d = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                if (rule.next != HALT && rule.next >= STATE_W'(NSTATES)) begin
                    ctl_d   = FAULT;
                    fault_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    m_ena_d   = 1'b1;
                    m_write_d = 1'b1;
                    wr_data_d = {4'b0, rule.newsym};
                    ctl_d     = WR_REQ;
                end
            end
            WR_WAIT: begin
                if (!m_busy) begin
                    ctl_d = MOVE;
                end
            end
            MOVE: begin
                steps_d = steps_q + CNT_W'(1);
`ifdef TM_SIGMA_EN
                if (sym_q == '0 && rule.newsym != '0) begin
                    sigma_d = sigma_q + ADDR_W'(1);
                end else if (sym_q != '0 && rule.newsym == '0) begin
                    sigma_d = sigma_q - ADDR_W'(1);
                end
`endif
                if (rule.next == HALT) begin
                    ctl_d  = DONE;
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else if ((rule.dir == DIR_R && head_q == LAST) ||
                             (rule.dir == DIR_L && head_q == '0)) begin
                    ctl_d   = FAULT;
                    fault_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    head_d     = (rule.dir == DIR_R) ? head_q + ADDR_W'(1) : head_q - ADDR_W'(1);
                    tm_state_d = rule.next;
                    m_addr_d   = head_d;
                    m_ena_d    = 1'b1;
                    m_write_d  = 1'b0;
                    ctl_d      = RD_REQ;
                end
            end
            default: ctl_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctl_q      <= IDLE;
            tm_state_q <= '0;
            sym_q      <= '0;
            steps_q    <= '0;
            head_q     <= '0;
            m_addr_q   <= '0;
            m_ena_q    <= 1'b0;
            m_write_q  <= 1'b0;
            wr_data_q  <= 8'h00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
`ifdef TM_SIGMA_EN
            sigma_q    <= '0;
`endif
        end else begin
            ctl_q      <= ctl_d;
            tm_state_q <= tm_state_d;
            sym_q      <= sym_d;
            steps_q    <= steps_d;
            head_q     <= head_d;
            m_addr_q   <= m_addr_d;
            m_ena_q    <= m_ena_d;
            m_write_q  <= m_write_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            fault_q    <= fault_d;
`ifdef TM_SIGMA_EN
            sigma_q    <= sigma_d;
`endif
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign fault   = fault_q;
    assign steps   = steps_q;
    assign head    = head_q;
    assign m_addr  = m_addr_q;
    assign m_ena   = m_ena_q;
    assign m_write = m_write_q;
    assign wr_data = wr_data_q;
`ifdef TM_SIGMA_EN
    assign sigma   = sigma_q;
`endif
endmodule

// File: tb/tb_tm_engine.sv
// Bench for tm_engine: behavioural DRAM controller, reference Turing-machine
// model feeding a scoreboard queue, one task per scenario.
`timescale 1ns/1ps
module tb_tm_engine;
    localparam int NST = 2;
    localparam int NSY = 5;
    localparam int TL  = 64;
    localparam int AB  = 6;
    localparam int AW  = 24;
    localparam int CW  = 40;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          rule_we = 1'b0;
    logic [7:0]    rule_addr = 8'h00;
    logic [8:0]    rule_wdata = 9'h000;
    logic          busy, done, fault;
    logic [CW-1:0] steps;
    logic [AW-1:0] head, m_addr;
    logic          m_ena, m_write;
    logic [7:0]    wr_data;
    logic [7:0]    rd_data;
    logic          m_ack, m_busy;
`ifdef TM_SIGMA_EN
    logic [AW-1:0] sigma;
`endif

    tm_engine #(
        .NSTATES(NST), .NSYMS(NSY), .TAPE_LEN(TL), .ADDR_W(AW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .rule_we(rule_we),
        .rule_addr(rule_addr), .rule_wdata(rule_wdata),
        .busy(busy), .done(done), .fault(fault), .steps(steps), .head(head),
        .m_addr(m_addr), .m_ena(m_ena), .m_write(m_write), .wr_data(wr_data),
        .rd_data(rd_data), .m_ack(m_ack), .m_busy(m_busy)
`ifdef TM_SIGMA_EN
        , .sigma(sigma)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit     dn;
        bit     ft;
        longint stp;
        int     hd;
        int     sg;
    } exp_t;

    exp_t       sb[$];
    logic [8:0] t_rule [16][16];
    logic [7:0] tape_e [TL];
    logic [7:0] mem [TL];
    int         tests_run = 0;
    int         tests_failed = 0;

    // DRAM controller model: ack after ack_dly cycles, busy for busy_len more.
    int         ack_dly = 0;
    int         busy_len = 0;
    bit         bad_rd = 1'b0;
    logic       fill = 1'b0;
    int         nwrites = 0;
    int         ph, cnt;
    logic [7:0] rdq;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= 0; cnt <= 0; m_ack <= 1'b0; m_busy <= 1'b0; rd_data <= 8'h00; rdq <= 8'h00;
        end else begin
            m_ack <= 1'b0;
            if (fill) for (int i = 0; i < TL; i++) mem[i] <= 8'(i) + 8'hA0;
            if (start && !busy) nwrites <= 0;
            case (ph)
                0: if (m_ena) begin cnt <= ack_dly; ph <= 1; end
                1: if (cnt == 0) begin
                       m_ack <= 1'b1; m_busy <= 1'b1; ph <= 2; cnt <= busy_len;
                       if (m_write) begin
                           mem[m_addr[AB-1:0]] <= wr_data;
                           nwrites <= nwrites + 1;
                       end else begin
                           rdq <= bad_rd ? 8'h07 : mem[m_addr[AB-1:0]];
                       end
                   end else cnt <= cnt - 1;
                default: if (cnt == 0) begin
                       m_busy <= 1'b0; rd_data <= rdq; ph <= 0;
                   end else cnt <= cnt - 1;
            endcase
        end
    end

    int ena_viol = 0;
    bit ack_last = 1'b0;
    always @(negedge clk) begin
        if (ack_last && m_ena) ena_viol++;
        ack_last = m_ack;
    end

    task automatic reset_model_table();
        for (int s = 0; s < 16; s++)
            for (int y = 0; y < 16; y++) t_rule[s][y] = {4'd0, 1'b1, 4'hF};
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        reset_model_table();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic prog(input int st, input int sy, input logic [3:0] ns, input logic dir, input logic [3:0] nx);
        @(posedge clk); #1;
        rule_we = 1'b1; rule_addr = {4'(st), 4'(sy)}; rule_wdata = {ns, dir, nx};
        if (st < NST && sy < NSY) t_rule[st][sy] = {ns, dir, nx};
        @(posedge clk); #1;
        rule_we = 1'b0;
    endtask

    task automatic load_bb();
        prog(0, 0, 4'd1, 1'b1, 4'd1);
        prog(0, 1, 4'd1, 1'b0, 4'd1);
        prog(1, 0, 4'd1, 1'b0, 4'd0);
        prog(1, 1, 4'd1, 1'b1, 4'hF);
    endtask

    // Fill the tape with garbage, then pulse start (optionally with a rule write).
    task automatic go(input bit with_rule, input logic [7:0] a, input logic [8:0] d);
        @(posedge clk); #1 fill = 1'b1;
        @(posedge clk); #1 fill = 1'b0; start = 1'b1;
        if (with_rule) begin rule_we = 1'b1; rule_addr = a; rule_wdata = d; end
        @(posedge clk); #1 start = 1'b0; rule_we = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && (done || fault)) begin to = 1'b0; break; end
        end
    endtask

    // Reference machine run on a freshly cleared tape; pushes the expectation.
    task automatic model_run(input bit bad);
        exp_t e;
        int h, st;
        logic [3:0] sym, ns, nx;
        logic dir;
        logic [8:0] r;
        for (int i = 0; i < TL; i++) tape_e[i] = 8'h00;
        e.dn = 1'b0; e.ft = 1'b0; e.stp = 0; e.sg = 0;
        h = TL / 2; st = 0;
        for (int n = 0; n < 10000; n++) begin
            if (bad || tape_e[h] >= NSY) begin e.ft = 1'b1; break; end
            sym = tape_e[h][3:0];
            r = t_rule[st][sym];
            ns = r[8:5]; dir = r[4]; nx = r[3:0];
            if (nx != 4'hF && nx >= NST) begin e.ft = 1'b1; break; end
            if (tape_e[h] == 0 && ns != 0) e.sg++;
            else if (tape_e[h] != 0 && ns == 0) e.sg--;
            tape_e[h] = {4'b0, ns};
            e.stp++;
            if (nx == 4'hF) begin e.dn = 1'b1; break; end
            if ((dir && h == TL - 1) || (!dir && h == 0)) begin e.ft = 1'b1; break; end
            h = dir ? h + 1 : h - 1;
            st = nx;
        end
        e.hd = h;
        sb.push_back(e);
    endtask

    function automatic int tape_diff();
        int n = 0;
        for (int i = 0; i < TL; i++) if (mem[i] !== tape_e[i]) n++;
        return n;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        tests_run++;
        if ({busy, done, fault} !== 3'b000 || steps !== '0 || head !== '0) begin
            tests_failed++;
            $display("FAIL reset_ctl busy=%0b done=%0b fault=%0b steps=%0d head=%0d want all 0", busy, done, fault, steps, head);
        end
        tests_run++;
        if ({m_ena, m_write} !== 2'b00 || m_addr !== '0 || wr_data !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_mem m_ena=%0b m_write=%0b m_addr=%0d wr_data=%0h want all 0", m_ena, m_write, m_addr, wr_data);
        end
        rst_n = 1'b1;
        reset_model_table();
        @(negedge clk);
    endtask

    task automatic test_bb22(input string nm);
        exp_t e; bit to;
        load_bb();
        model_run(1'b0);
        go(1'b0, 8'h00, 9'h000);
        wait_end(20000, to);
        e = sb.pop_front();
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL %s_timeout busy=%0b want run to end", nm, busy); end
        tests_run++;
        if ({done, fault} !== {e.dn, e.ft}) begin
            tests_failed++; $display("FAIL %s_flags done=%0b fault=%0b want %0b %0b", nm, done, fault, e.dn, e.ft);
        end
        // Halting transition does not move the head, so it stays on cell 31.
        tests_run++;
        if (steps !== CW'(e.stp) || steps !== 40'd6 || head !== AW'(e.hd) || head !== 24'd31) begin
            tests_failed++; $display("FAIL %s_pos steps=%0d head=%0d want 6 31", nm, steps, head);
        end
        tests_run++;
        if (tape_diff() != 0 || nwrites != TL + 6) begin
            tests_failed++; $display("FAIL %s_tape bad_cells=%0d writes=%0d want 0 %0d", nm, tape_diff(), nwrites, TL + 6);
        end
        tests_run++;
        if (ena_viol != 0) begin tests_failed++; $display("FAIL %s_ena_after_ack count=%0d want 0", nm, ena_viol); end
`ifdef TM_SIGMA_EN
        tests_run++;
        if (sigma !== AW'(e.sg) || sigma !== 24'd4) begin
            tests_failed++; $display("FAIL %s_sigma got=%0d want 4", nm, sigma);
        end
`endif
    endtask

    task automatic test_overrun(input logic dir, input int want_steps, input int want_head);
        exp_t e; bit to;
        prog(0, 0, 4'd1, dir, 4'd0);
        model_run(1'b0);
        go(1'b0, 8'h00, 9'h000);
        wait_end(20000, to);
        e = sb.pop_front();
        tests_run++;
        if (to || {done, fault} !== {e.dn, e.ft} || fault !== 1'b1) begin
            tests_failed++; $display("FAIL overrun%0b_flags done=%0b fault=%0b want 0 1", dir, done, fault);
        end
        tests_run++;
        if (steps !== CW'(e.stp) || head !== AW'(e.hd) || steps !== CW'(want_steps) || head !== AW'(want_head)) begin
            tests_failed++; $display("FAIL overrun%0b_pos steps=%0d head=%0d want %0d %0d", dir, steps, head, want_steps, want_head);
        end
        tests_run++;
        if (tape_diff() != 0) begin tests_failed++; $display("FAIL overrun%0b_tape bad_cells=%0d want 0", dir, tape_diff()); end
    endtask

    task automatic test_unprogrammed();
        exp_t e; bit to;
        do_reset();
        prog(2, 0, 4'd1, 1'b0, 4'd0);
        prog(0, 7, 4'd1, 1'b0, 4'd0);
        model_run(1'b0);
        go(1'b0, 8'h00, 9'h000);
        wait_end(20000, to);
        e = sb.pop_front();
        tests_run++;
        if (to || done !== 1'b1 || fault !== 1'b0 || steps !== CW'(e.stp) || steps !== 40'd1) begin
            tests_failed++; $display("FAIL unprog_flags done=%0b fault=%0b steps=%0d want 1 0 1", done, fault, steps);
        end
        tests_run++;
        if (head !== AW'(TL / 2) || mem[TL / 2] !== 8'h00 || nwrites != TL + 1) begin
            tests_failed++; $display("FAIL unprog_cell head=%0d cell=%0h writes=%0d want %0d 0 %0d", head, mem[TL / 2], nwrites, TL / 2, TL + 1);
        end
    endtask

    task automatic test_no_write_fault(input bit bad, input string nm);
        exp_t e; bit to;
        bad_rd = bad;
        model_run(bad);
        go(1'b0, 8'h00, 9'h000);
        wait_end(20000, to);
        bad_rd = 1'b0;
        e = sb.pop_front();
        tests_run++;
        if (to || {done, fault} !== {e.dn, e.ft} || fault !== 1'b1 || steps !== CW'(e.stp) || steps !== '0) begin
            tests_failed++; $display("FAIL %s done=%0b fault=%0b steps=%0d want 0 1 0", nm, done, fault, steps);
        end
        tests_run++;
        if (nwrites != TL || head !== AW'(e.hd) || tape_diff() != 0) begin
            tests_failed++; $display("FAIL %s_writes writes=%0d head=%0d want %0d %0d", nm, nwrites, head, TL, e.hd);
        end
    endtask

    task automatic test_reset_midrun();
        exp_t e; bit to;
        load_bb();
        go(1'b0, 8'h00, 9'h000);
        for (int i = 0; i < 5000 && steps != 40'd2; i++) @(negedge clk);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (busy !== 1'b0 || m_ena !== 1'b0 || steps !== '0) begin
            tests_failed++; $display("FAIL midrun_reset busy=%0b m_ena=%0b steps=%0d want 0 0 0", busy, m_ena, steps);
        end
        reset_model_table();
        @(negedge clk);
        rst_n = 1'b1;
        load_bb();
        model_run(1'b0);
        go(1'b0, 8'h00, 9'h000);
        repeat (20) @(negedge clk);
        // start and a table write while busy must both be ignored.
        @(posedge clk); #1;
        start = 1'b1; rule_we = 1'b1; rule_addr = 8'h00; rule_wdata = {4'd0, 1'b1, 4'hF};
        @(posedge clk); #1;
        start = 1'b0; rule_we = 1'b0;
        wait_end(20000, to);
        e = sb.pop_front();
        tests_run++;
        if (to || done !== 1'b1 || steps !== CW'(e.stp) || steps !== 40'd6 || head !== AW'(e.hd)) begin
            tests_failed++; $display("FAIL midrun_rerun done=%0b steps=%0d head=%0d want 1 6 %0d", done, steps, head, e.hd);
        end
        tests_run++;
        if (nwrites != TL + 6 || tape_diff() != 0) begin
            tests_failed++; $display("FAIL midrun_busy_ignore writes=%0d bad_cells=%0d want %0d 0", nwrites, tape_diff(), TL + 6);
        end
    endtask

    task automatic test_start_with_rule();
        exp_t e; bit to;
        do_reset();
        prog(0, 0, 4'd1, 1'b1, 4'd1);
        prog(0, 1, 4'd1, 1'b0, 4'd1);
        prog(1, 0, 4'd1, 1'b0, 4'd0);
        t_rule[1][1] = {4'd1, 1'b1, 4'hF};
        model_run(1'b0);
        go(1'b1, 8'h11, {4'd1, 1'b1, 4'hF});
        wait_end(20000, to);
        e = sb.pop_front();
        tests_run++;
        if (to || done !== 1'b1 || steps !== CW'(e.stp) || head !== AW'(e.hd)) begin
            tests_failed++; $display("FAIL same_cycle_run done=%0b steps=%0d head=%0d want 1 %0d %0d", done, steps, head, e.stp, e.hd);
        end
        tests_run++;
        if (mem[31] !== 8'h01 || tape_diff() != 0) begin
            tests_failed++; $display("FAIL same_cycle_rule cell31=%0h bad_cells=%0d want 01 0", mem[31], tape_diff());
        end
    endtask

    initial begin
        reset_model_table();
        test_reset();
        test_bb22("bb22");
        test_overrun(1'b1, 32, 63);
        test_overrun(1'b0, 33, 0);
        test_unprogrammed();
        prog(0, 0, 4'd1, 1'b1, 4'd5);
        test_no_write_fault(1'b0, "illegal_next");
        load_bb();
        test_no_write_fault(1'b1, "bad_symbol");
        ack_dly = 20; busy_len = 15;
        test_bb22("slow_dram");
        ack_dly = 0; busy_len = 0;
        test_reset_midrun();
        test_start_with_rule();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL global_timeout time=%0t want bench to finish", $time);
        $fatal(1, "bench timeout");
    end
endmodule
